// File: rtl/adc_pkg.sv
// Shared types and constants for the SPI ADC capture front end.
package adc_pkg;

  localparam int unsigned CFG_W        = 6;
  localparam int unsigned CONVST_PULSE = 2;

  typedef enum logic [1:0] {StIdle, StConv, StShift, StDone} state_e;

  // Config bit sent during SCLK period idx, MSB first; zero once the word is exhausted.
  function automatic logic cfg_bit(logic [CFG_W-1:0] cfg, int unsigned idx);
    logic [CFG_W-1:0] t;
    t = cfg << idx;
    return t[CFG_W-1];
  endfunction

endpackage

// File: rtl/adc_spi_capture_if.sv
// Host request/sample signals and ADC pins of the capture block, grouped in one bundle.
interface adc_spi_capture_if
  import adc_pkg::*;
#(
  parameter int unsigned S = 12
);
  logic             start;
  logic [CFG_W-1:0] cfg;
  logic             busy;
  logic [S-1:0]     sample;
  logic             valid;
  logic             adc_convst;
  logic             adc_sclk;
  logic             adc_sdi;
  logic             adc_sdo;

  modport master (
    input  start, cfg, adc_sdo,
    output busy, sample, valid, adc_convst, adc_sclk, adc_sdi
  );

  modport slave (
    output start, cfg, adc_sdo,
    input  busy, sample, valid, adc_convst, adc_sclk, adc_sdi
  );
endinterface

// File: rtl/sclk_gen.sv
// SCLK generator: CLK_DIV-cycle low then high phases while enabled, with strobes
// marking the cycle before each SCLK rising and falling edge.
module sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic clr_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned   CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            last;

  assign last = (cnt_q == CntLast);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (last) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = en_i & last & ~sclk_q;
  assign fall_o = en_i & last & sclk_q;

endmodule

// File: rtl/adc_spi_capture.sv
// LTC2308-style capture: CONVST pulse, conversion wait, then a combined config-out /
// sample-in SPI transfer; the sample is presented with a one-cycle valid strobe.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int unsigned S       = 12,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned T_CONV  = 80
) (
  input logic               clk_i,
  input logic               clr_ni,
  adc_spi_capture_if.master adc_if
);
  localparam int unsigned   CW       = $clog2(T_CONV);
  localparam int unsigned   BW       = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] ConvLast = CW'(T_CONV - 1);
  localparam logic [BW-1:0] BitLast  = BW'(S - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [S-1:0]     shift_q, shift_d;
  logic [S-1:0]     sample_q, sample_d;
  logic             convst_q, convst_d;
  logic             sdi_q, sdi_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             sclk, sclk_rise, sclk_fall;

  sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_i  (clk_i),
    .clr_ni (clr_ni),
    .en_i   (state_q == StShift),
    .sclk_o (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    cfg_d    = cfg_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    sdi_d    = sdi_q;

    unique case (state_q)
      StIdle: begin
        if (adc_if.start) begin
          cfg_d   = adc_if.cfg;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        if (cnt_q == ConvLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          sdi_d   = cfg_bit(cfg_q, 0);
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        // ADC_SDO is captured on the CLK edge that raises SCLK.
        if (sclk_rise) shift_d = {shift_q[S-2:0], adc_if.adc_sdo};
        if (sclk_fall) begin
          if (bit_q == BitLast) begin
            sdi_d    = 1'b0;
            bit_d    = '0;
            sample_d = shift_q;
            state_d  = StDone;
          end else begin
            bit_d = bit_q + 1'b1;
            sdi_d = cfg_bit(cfg_q, 32'(bit_q) + 1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are computed from the next state so they come straight from flops.
    convst_d = (state_d == StConv) && (32'(cnt_d) < CONVST_PULSE);
    busy_d   = (state_d != StIdle);
    valid_d  = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      cfg_q    <= '0;
      shift_q  <= '0;
      sample_q <= '0;
      convst_q <= 1'b0;
      sdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      cfg_q    <= cfg_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      convst_q <= convst_d;
      sdi_q    <= sdi_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign adc_if.adc_convst = convst_q;
  assign adc_if.adc_sclk   = sclk;
  assign adc_if.adc_sdi    = sdi_q;
  assign adc_if.busy       = busy_q;
  assign adc_if.valid      = valid_q;
  assign adc_if.sample     = sample_q;

endmodule
